// File: rtl/pipe_ctrl_if.sv
// Pipeline-controller interface: stage status/requests in, stall/flush/redirect out,
// plus the control-register write (from MEM) and read (from ID) ports.
interface pipe_ctrl_if #(
    parameter int unsigned IRQ_W = 8
);
    logic             if_busy;
    logic             mem_busy;
    logic             ld_hazard;
    logic [IRQ_W-1:0] irq;
    logic             ex_en;
    logic [29:0]      ex_pc;
    logic             mem_en;
    logic [29:0]      mem_pc;
    logic [2:0]       mem_exp_code;
    logic [1:0]       mem_ctrl_op;
    logic [2:0]       mem_cr_addr;
    logic [31:0]      mem_cr_wdata;
    logic [2:0]       cr_rd_addr;
    logic [31:0]      cr_rd_data;
    logic             if_stall;
    logic             id_stall;
    logic             ex_stall;
    logic             mem_stall;
    logic             if_flush;
    logic             id_flush;
    logic             ex_flush;
    logic             mem_flush;
    logic [29:0]      new_pc;
    logic             new_pc_valid;

    // Pipeline side: drives stage status, consumes control.
    modport master (
        output if_busy, mem_busy, ld_hazard, irq, ex_en, ex_pc, mem_en, mem_pc,
               mem_exp_code, mem_ctrl_op, mem_cr_addr, mem_cr_wdata, cr_rd_addr,
        input  cr_rd_data, if_stall, id_stall, ex_stall, mem_stall,
               if_flush, id_flush, ex_flush, mem_flush, new_pc, new_pc_valid
    );

    // Controller side.
    modport slave (
        input  if_busy, mem_busy, ld_hazard, irq, ex_en, ex_pc, mem_en, mem_pc,
               mem_exp_code, mem_ctrl_op, mem_cr_addr, mem_cr_wdata, cr_rd_addr,
        output cr_rd_data, if_stall, id_stall, ex_stall, mem_stall,
               if_flush, id_flush, ex_flush, mem_flush, new_pc, new_pc_valid
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: per-stage stall/flush, exception/interrupt entry,
// EXRT return, and the control-register file (STATUS, INT_MASK, EXP_CODE, EPC, CYCLE).
module pipe_ctrl #(
    parameter logic [29:0] EXC_VECTOR = 30'h0000_0010,
    parameter int unsigned IRQ_W      = 8
) (
    input logic        clk,
    input logic        reset,
    pipe_ctrl_if.slave bus
);
    localparam logic [2:0] CrStatus  = 3'd0;
    localparam logic [2:0] CrIntMask = 3'd1;
    localparam logic [2:0] CrExpCode = 3'd2;
    localparam logic [2:0] CrEpc     = 3'd3;
    localparam logic [2:0] CrCycle   = 3'd4;

    localparam logic [1:0] OpNop  = 2'd0;
    localparam logic [1:0] OpWrcr = 2'd1;
    localparam logic [1:0] OpExrt = 2'd2;

    // The single event taken this cycle, already priority-resolved.
    typedef enum logic [2:0] {EvNone, EvStall, EvExc, EvExrt, EvIrq, EvWrcr} event_e;

    logic             ie_q, ie_d;
    logic             pre_ie_q, pre_ie_d;
    logic [IRQ_W-1:0] int_mask_q, int_mask_d;
    logic [2:0]       exp_code_q, exp_code_d;
    logic [29:0]      epc_q, epc_d;
    logic [31:0]      cycle_q, cycle_d;
    logic [IRQ_W-1:0] irq_meta_q, irq_s_q;

    event_e ev;
    logic   irq_pend;

    assign irq_pend = |(irq_s_q & ~int_mask_q);

    // Resolve the highest-priority event; memory stalls freeze everything.
    always_comb begin
        ev = EvNone;
        if (reset) begin
            ev = EvNone;
        end else if (bus.if_busy || bus.mem_busy) begin
            ev = EvStall;
        end else if (bus.mem_en && (bus.mem_exp_code != 3'd0)) begin
            ev = EvExc;
        end else if (bus.mem_en && (bus.mem_ctrl_op == OpExrt)) begin
            ev = EvExrt;
        end else if (ie_q && irq_pend && bus.ex_en &&
                     ((bus.mem_ctrl_op == OpNop) || !bus.mem_en)) begin
            ev = EvIrq;
        end else if (bus.mem_en && (bus.mem_ctrl_op == OpWrcr)) begin
            ev = EvWrcr;
        end
    end

    // Stage control outputs; a redirect overrides the load-use interlock.
    always_comb begin
        bus.if_stall     = 1'b0;
        bus.id_stall     = 1'b0;
        bus.ex_stall     = 1'b0;
        bus.mem_stall    = 1'b0;
        bus.if_flush     = 1'b0;
        bus.id_flush     = 1'b0;
        bus.ex_flush     = 1'b0;
        bus.mem_flush    = 1'b0;
        bus.new_pc       = '0;
        bus.new_pc_valid = 1'b0;
        unique case (ev)
            EvStall: begin
                bus.if_stall  = 1'b1;
                bus.id_stall  = 1'b1;
                bus.ex_stall  = 1'b1;
                bus.mem_stall = 1'b1;
            end
            EvExc, EvExrt: begin
                bus.if_flush     = 1'b1;
                bus.id_flush     = 1'b1;
                bus.ex_flush     = 1'b1;
                bus.mem_flush    = 1'b1;
                bus.new_pc_valid = 1'b1;
                bus.new_pc       = (ev == EvExc) ? EXC_VECTOR : epc_q;
            end
            EvIrq: begin
                // MEM instruction is allowed to retire; EX and younger are squashed.
                bus.if_flush     = 1'b1;
                bus.id_flush     = 1'b1;
                bus.ex_flush     = 1'b1;
                bus.new_pc_valid = 1'b1;
                bus.new_pc       = EXC_VECTOR;
            end
            default: begin
                if (!reset && bus.ld_hazard) begin
                    bus.if_stall = 1'b1;
                    bus.id_flush = 1'b1;
                end
            end
        endcase
    end

    // Control-register next state driven by the taken event.
    always_comb begin
        ie_d       = ie_q;
        pre_ie_d   = pre_ie_q;
        int_mask_d = int_mask_q;
        exp_code_d = exp_code_q;
        epc_d      = epc_q;
        cycle_d    = cycle_q + 32'd1;
        unique case (ev)
            EvExc: begin
                epc_d      = bus.mem_pc;
                exp_code_d = bus.mem_exp_code;
                pre_ie_d   = ie_q;
                ie_d       = 1'b0;
            end
            EvExrt: begin
                ie_d = pre_ie_q;
            end
            EvIrq: begin
                epc_d      = bus.ex_pc;
                exp_code_d = 3'd1;
                pre_ie_d   = ie_q;
                ie_d       = 1'b0;
            end
            EvWrcr: begin
                case (bus.mem_cr_addr)
                    CrStatus: begin
                        ie_d     = bus.mem_cr_wdata[0];
                        pre_ie_d = bus.mem_cr_wdata[1];
                    end
                    CrIntMask: int_mask_d = bus.mem_cr_wdata[IRQ_W-1:0];
                    CrExpCode: exp_code_d = bus.mem_cr_wdata[2:0];
                    CrEpc:     epc_d      = bus.mem_cr_wdata[31:2];
                    CrCycle:   cycle_d    = bus.mem_cr_wdata;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Register file and two-flop irq synchronizer, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ie_q       <= 1'b0;
            pre_ie_q   <= 1'b0;
            int_mask_q <= '1;
            exp_code_q <= '0;
            epc_q      <= '0;
            cycle_q    <= '0;
            irq_meta_q <= '0;
            irq_s_q    <= '0;
        end else begin
            ie_q       <= ie_d;
            pre_ie_q   <= pre_ie_d;
            int_mask_q <= int_mask_d;
            exp_code_q <= exp_code_d;
            epc_q      <= epc_d;
            cycle_q    <= cycle_d;
            irq_meta_q <= bus.irq;
            irq_s_q    <= irq_meta_q;
        end
    end

    // Combinational read port: shows current register contents, not same-cycle writes.
    always_comb begin
        bus.cr_rd_data = '0;
        case (bus.cr_rd_addr)
            CrStatus:  bus.cr_rd_data = {30'd0, pre_ie_q, ie_q};
            CrIntMask: bus.cr_rd_data = 32'(int_mask_q);
            CrExpCode: bus.cr_rd_data = {29'd0, exp_code_q};
            CrEpc:     bus.cr_rd_data = {epc_q, 2'b00};
            CrCycle:   bus.cr_rd_data = cycle_q;
            default:   bus.cr_rd_data = '0;
        endcase
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a table of single-cycle control vectors plus
// hand-written sequences for interrupt entry, busy-deferred exception, EXRT and CYCLE wrap.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    pipe_ctrl_if #(.IRQ_W(8)) bus ();

    pipe_ctrl #(
        .EXC_VECTOR(30'h10),
        .IRQ_W     (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // sf = {if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush}
    typedef struct {
        logic        rst;
        logic        ifb;
        logic        memb;
        logic        ldh;
        logic        men;
        logic [2:0]  code;
        logic [1:0]  op;
        logic        exen;
        logic [7:0]  sf;
        logic        npv;
        logic [29:0] npc;
    } vec_t;

    vec_t vecs [12];

    task automatic idle_inputs();
        bus.if_busy      = 1'b0;
        bus.mem_busy     = 1'b0;
        bus.ld_hazard    = 1'b0;
        bus.irq          = '0;
        bus.ex_en        = 1'b0;
        bus.ex_pc        = '0;
        bus.mem_en       = 1'b0;
        bus.mem_pc       = '0;
        bus.mem_exp_code = '0;
        bus.mem_ctrl_op  = '0;
        bus.mem_cr_addr  = 3'd5;
        bus.mem_cr_wdata = '0;
        bus.cr_rd_addr   = '0;
    endtask

    task automatic check_ctl(input string name, input logic [7:0] sf, input logic npv,
                             input logic [29:0] npc, input logic chk_pc);
        logic [7:0] act;
        act = {bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall,
               bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush};
        n_cmp++;
        if (act !== sf || bus.new_pc_valid !== npv || (chk_pc && bus.new_pc !== npc)) begin
            n_err++;
            $display("FAIL %s: got sf=%b npv=%b pc=%h, want sf=%b npv=%b pc=%h",
                     name, act, bus.new_pc_valid, bus.new_pc, sf, npv, npc);
        end
    endtask

    task automatic check_cr(input string name, input logic [2:0] addr, input logic [31:0] exp);
        bus.cr_rd_addr = addr;
        #1;
        n_cmp++;
        if (bus.cr_rd_data !== exp) begin
            n_err++;
            $display("FAIL %s: got cr[%0d]=%h, want %h", name, addr, bus.cr_rd_data, exp);
        end
    endtask

    initial begin
        //            rst   ifb   memb  ldh   men   code  op    exen  sf            npv   npc
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 2'd0, 1'b0, 8'b0000_0000, 1'b0, 30'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 8'b0000_0000, 1'b0, 30'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 8'b1111_0000, 1'b0, 30'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 2'd0, 1'b0, 8'b1111_0000, 1'b0, 30'h0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 8'b1000_0100, 1'b0, 30'h0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 2'd0, 1'b0, 8'b0000_1111, 1'b1, 30'h10};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd2, 1'b0, 8'b0000_1111, 1'b1, 30'h0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 2'd2, 1'b0, 8'b0000_1111, 1'b1, 30'h10};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 2'd1, 1'b0, 8'b1000_0100, 1'b0, 30'h0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 2'd0, 1'b1, 8'b0000_0000, 1'b0, 30'h0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 1'b1, 8'b1000_0100, 1'b0, 30'h0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 2'd1, 1'b0, 8'b1111_0000, 1'b0, 30'h0};

        // Reset with hostile inputs: outputs must be forced low.
        idle_inputs();
        reset            = 1'b1;
        bus.irq          = 8'hFF;
        bus.mem_en       = 1'b1;
        bus.mem_exp_code = 3'd2;
        @(negedge clk);
        #1 check_ctl("reset_outputs", 8'h00, 1'b0, 30'h0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        check_cr("rst_status", 3'd0, 32'h0);
        check_cr("rst_mask", 3'd1, 32'h0000_00FF);
        check_cr("rst_cycle0", 3'd4, 32'h0);
        @(negedge clk);
        check_cr("rst_cycle1", 3'd4, 32'h1);

        // Table of single-cycle control vectors (ie=0, epc stays 0 throughout).
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            reset            = vecs[i].rst;
            bus.if_busy      = vecs[i].ifb;
            bus.mem_busy     = vecs[i].memb;
            bus.ld_hazard    = vecs[i].ldh;
            bus.mem_en       = vecs[i].men;
            bus.mem_exp_code = vecs[i].code;
            bus.mem_ctrl_op  = vecs[i].op;
            bus.ex_en        = vecs[i].exen;
            #1 check_ctl($sformatf("vec%0d", i), vecs[i].sf, vecs[i].npv, vecs[i].npc,
                         vecs[i].npv | vecs[i].rst);
        end

        // Interrupt entry: unmask line 0, enable, raise irq[0].
        @(negedge clk);
        idle_inputs();
        bus.mem_en       = 1'b1;
        bus.mem_ctrl_op  = 2'd1;
        bus.mem_cr_addr  = 3'd1;
        bus.mem_cr_wdata = 32'h0000_00FE;
        @(negedge clk);
        bus.mem_cr_addr  = 3'd0;
        bus.mem_cr_wdata = 32'h1;
        @(negedge clk);
        bus.mem_en      = 1'b0;
        bus.mem_ctrl_op = 2'd0;
        bus.irq         = 8'h01;
        bus.ex_en       = 1'b1;
        bus.ex_pc       = 30'h40;
        #1 check_ctl("irq_sync0", 8'h00, 1'b0, 30'h0, 1'b0);
        @(negedge clk);
        #1 check_ctl("irq_sync1", 8'h00, 1'b0, 30'h0, 1'b0);
        @(negedge clk);
        #1 check_ctl("irq_take", 8'b0000_1110, 1'b1, 30'h10, 1'b1);
        @(negedge clk);
        #1 check_ctl("irq_ie_off", 8'h00, 1'b0, 30'h0, 1'b0);
        bus.irq   = 8'h00;
        bus.ex_en = 1'b0;
        check_cr("irq_epc", 3'd3, 32'h0000_0100);
        check_cr("irq_code", 3'd2, 32'h1);
        check_cr("irq_status", 3'd0, 32'h2);

        // MEM exception held off by mem_busy, then taken.
        @(negedge clk);
        bus.mem_en       = 1'b1;
        bus.mem_ctrl_op  = 2'd1;
        bus.mem_cr_addr  = 3'd0;
        bus.mem_cr_wdata = 32'h1;
        @(negedge clk);
        bus.mem_ctrl_op  = 2'd0;
        bus.mem_exp_code = 3'd3;
        bus.mem_pc       = 30'h25;
        bus.mem_busy     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1 check_ctl($sformatf("exc_busy%0d", i), 8'b1111_0000, 1'b0, 30'h0, 1'b0);
        end
        @(negedge clk);
        bus.mem_busy = 1'b0;
        #1 check_ctl("exc_take", 8'b0000_1111, 1'b1, 30'h10, 1'b1);
        @(negedge clk);
        bus.mem_en       = 1'b0;
        bus.mem_exp_code = 3'd0;
        check_cr("exc_epc", 3'd3, 32'h0000_0094);
        check_cr("exc_code", 3'd2, 32'h3);
        check_cr("exc_status", 3'd0, 32'h2);

        // EXRT returns to epc and restores ie from pre_ie.
        @(negedge clk);
        bus.mem_en      = 1'b1;
        bus.mem_ctrl_op = 2'd2;
        #1 check_ctl("exrt_take", 8'b0000_1111, 1'b1, 30'h25, 1'b1);
        @(negedge clk);
        bus.mem_en      = 1'b0;
        bus.mem_ctrl_op = 2'd0;
        check_cr("exrt_status", 3'd0, 32'h3);

        // CYCLE load and wrap.
        @(negedge clk);
        bus.mem_en       = 1'b1;
        bus.mem_ctrl_op  = 2'd1;
        bus.mem_cr_addr  = 3'd4;
        bus.mem_cr_wdata = 32'hFFFF_FFFE;
        @(negedge clk);
        bus.mem_en      = 1'b0;
        bus.mem_ctrl_op = 2'd0;
        check_cr("cyc_load", 3'd4, 32'hFFFF_FFFE);
        @(negedge clk);
        check_cr("cyc_max", 3'd4, 32'hFFFF_FFFF);
        @(negedge clk);
        check_cr("cyc_wrap", 3'd4, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core (IF/ID/EX/MEM/WB).
- Generates per-stage stall/flush for the IF, ID, EX and MEM pipeline registers.
- Takes synchronous exceptions at MEM and external interrupts at EX, and issues redirect PCs.
- Owns the control-register file (status, interrupt mask, exception code, EPC, cycle counter) and services WRCR/EXRT at MEM.

Parameters:
- EXC_VECTOR, 30'h0000_0010, word address of the exception/interrupt handler.
- IRQ_W, 8, number of external interrupt lines.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- if_busy  in  1  IF stage waiting on memory.
- mem_busy  in  1  MEM stage waiting on memory.
- ld_hazard  in  1  load-use interlock request from decoder.
- irq  in  IRQ_W  asynchronous level interrupt requests.
- ex_en  in  1  EX-stage instruction valid.
- ex_pc  in  30  EX-stage word PC.
- mem_en  in  1  MEM-stage instruction valid.
- mem_pc  in  30  MEM-stage word PC.
- mem_exp_code  in  3  0 NO_EXP, 1 EXT_INT, 2 UNDEF, 3 OVF, 4 MISALIGN, 5 PRV_VIO.
- mem_ctrl_op  in  2  0 NOP, 1 WRCR, 2 EXRT.
- mem_cr_addr  in  3  control-register write address.
- mem_cr_wdata  in  32  control-register write data.
- cr_rd_addr  in  3  control-register read address (from ID).
- cr_rd_data  out  32  combinational read data.
- if_stall, id_stall, ex_stall, mem_stall  out  1 each  stage-register hold.
- if_flush, id_flush, ex_flush, mem_flush  out  1 each  stage-register bubble.
- new_pc  out  30  redirect target.
- new_pc_valid  out  1  redirect strobe for the IF PC.

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. All registers clear on the first rising clk edge with reset=1:
  - ie=0, pre_ie=0, int_mask=all 1s (all lines masked), exp_code=0, epc=0, cycle=0, irq sync flops=0.
- Reset outputs: all stall/flush/new_pc_valid are 0 and new_pc=0 in any cycle with reset=1, regardless of other inputs.
- Control-register map:
  - 0 STATUS: [1]=pre_ie, [0]=ie.
  - 1 INT_MASK: [IRQ_W-1:0], 1 = masked.
  - 2 EXP_CODE: [2:0].
  - 3 EPC: [31:2] = epc, [1:0] = 0.
  - 4 CYCLE: 32-bit free-running counter, +1 every non-reset cycle, wraps FFFF_FFFF→0.
  - 5–7: read 0, writes ignored.
- Read port: cr_rd_data is combinational and returns the current register value, not any same-cycle write.
- irq synchronizer: two-flop per line; irq_s is the second stage. An irq edge is visible to the controller 2 cycles after it appears.
- Stall: busy = if_busy | mem_busy. When busy=1, all four *_stall=1 and all *_flush=0; no exception, interrupt, EXRT or WRCR is taken that cycle. Deferred events are re-evaluated each cycle while the stage registers hold.
- Load-use (busy=0, no redirect): if_stall=1, id_flush=1 (bubble into EX). Other stall/flush signals stay 0.
- Events are evaluated combinationally when busy=0. Priority, highest first:
  - E1 MEM exception: mem_en=1 and mem_exp_code≠0.
    - All four flushes =1; new_pc_valid=1, new_pc=EXC_VECTOR.
    - Next edge: epc←mem_pc, exp_code←mem_exp_code, pre_ie←ie, ie←0.
  - E2 EXRT: mem_en=1 and mem_ctrl_op=2.
    - All four flushes =1; new_pc_valid=1, new_pc=epc.
    - Next edge: ie←pre_ie.
  - E3 interrupt: ie=1, (irq_s & ~int_mask)≠0, ex_en=1, and mem_ctrl_op=0 or mem_en=0.
    - if_flush=id_flush=ex_flush=1, mem_flush=0 (the MEM instruction completes).
    - new_pc_valid=1, new_pc=EXC_VECTOR.
    - Next edge: epc←ex_pc, exp_code←1, pre_ie←ie, ie←0.
  - E4 WRCR: mem_en=1 and mem_ctrl_op=1. Next edge: writes mem_cr_wdata to mem_cr_addr. No flush.
    - Writes to CYCLE load the counter; the +1 is suppressed that cycle.
    - Writes to EXP_CODE take [2:0]; writes to EPC take [31:2].
- Any redirect (E1–E3) overrides ld_hazard: if_stall=0.
- Only one event is taken per cycle. A WRCR losing to E3 is impossible by the E3 condition.
- new_pc_valid is a single-cycle combinational pulse, with no state carried beyond the registers above.
- Reset mid-operation: pending deferred events are discarded. The irq sync flops clear, so irq needs 2 cycles after reset release to be seen.

Test Plan:
- Reset with irq=8'hFF, mem_en=1, mem_exp_code=2 → all outputs 0; after release: STATUS=0, INT_MASK=8'hFF, CYCLE=1 one cycle later.
- WRCR addr1 data 8'hFE, then WRCR addr0 data 1, irq[0] rises with ex_en=1, ex_pc=30'h40 → 2 cycles after irq visible: if/id/ex_flush=1, mem_flush=0, new_pc=30'h10; next cycle EPC read=32'h100, EXP_CODE=1, STATUS=2'b10.
- mem_en=1, mem_exp_code=3, mem_pc=30'h25 while mem_busy=1 for 3 cycles → no flush during busy; first non-busy cycle: all flushes=1, new_pc=30'h10; then EPC read=32'h94, EXP_CODE=3.
- After the previous entry, EXRT at MEM → all flushes=1, new_pc=30'h25, then STATUS[0]=pre_ie.
- ld_hazard=1 alone → if_stall=1, id_flush=1, others 0; ld_hazard=1 with mem_exp_code=4 → if_stall=0, all flushes=1.
- WRCR addr4 data FFFF_FFFE → CYCLE reads FFFF_FFFE, then FFFF_FFFF, then 0000_0000 (wrap).
